// File: rtl/alu_share_arbiter.sv
// Round-robin sharer of one combinational ALU between two requesters.
// Operands are registered on accept, executed for one cycle, and the result is held until consumed.
module alu_share_arbiter #(
   parameter int NREQ = 2,
   parameter int DW   = 32
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic [NREQ-1:0]         req_valid,
   output logic [NREQ-1:0]         req_ready,
   input  logic [NREQ-1:0][DW-1:0] req_in_1,
   input  logic [NREQ-1:0][DW-1:0] req_in_2,
   input  logic [NREQ-1:0][3:0]    req_control,
   output logic [NREQ-1:0]         resp_valid,
   input  logic [NREQ-1:0]         resp_ready,
   output logic [DW-1:0]           resp_result,
   output logic                    resp_bcond,
   output logic [DW-1:0]           alu_in_1,
   output logic [DW-1:0]           alu_in_2,
   output logic [3:0]              alu_control,
   input  logic [DW-1:0]           alu_result,
   input  logic                    alu_bcond,
   output logic                    busy,
   output logic                    grant_id
);

   // Opcode 15 makes the ALU produce result 0 / bcond 0 while it is not in use.
   localparam logic [3:0] CTRL_IDLE = 4'hF;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic            prio_q, prio_d;
   logic            grant_q, grant_d;
   logic [DW-1:0]   in_1_q, in_1_d;
   logic [DW-1:0]   in_2_q, in_2_d;
   logic [3:0]      ctrl_q, ctrl_d;
   logic [DW-1:0]   result_q, result_d;
   logic            bcond_q, bcond_d;
   logic [NREQ-1:0] resp_valid_q, resp_valid_d;
   logic            busy_q, busy_d;

   logic win_s;
   logic any_s;
   logic accept_s;
   logic resp_fire_s;

   // prio_q names the requester that wins a tie; it always points away from the last winner.
   always_comb begin
      win_s = 1'b0;
      any_s = 1'b0;
      case (req_valid)
         2'b01: begin
            win_s = 1'b0;
            any_s = 1'b1;
         end
         2'b10: begin
            win_s = 1'b1;
            any_s = 1'b1;
         end
         2'b11: begin
            win_s = prio_q;
            any_s = 1'b1;
         end
         default: begin
            win_s = 1'b0;
            any_s = 1'b0;
         end
      endcase
   end

   assign accept_s    = (state_q == ST_IDLE) && any_s;
   assign resp_fire_s = (state_q == ST_RESP) && resp_valid_q[grant_q] && resp_ready[grant_q];

   // Ready is held low while reset is asserted, even though the state register already reads IDLE.
   always_comb begin
      req_ready = '0;
      if (reset_n && accept_s) begin
         req_ready[win_s] = 1'b1;
      end else begin
         req_ready = '0;
      end
   end

   always_comb begin
      state_d      = state_q;
      prio_d       = prio_q;
      grant_d      = grant_q;
      in_1_d       = in_1_q;
      in_2_d       = in_2_q;
      ctrl_d       = ctrl_q;
      result_d     = result_q;
      bcond_d      = bcond_q;
      resp_valid_d = resp_valid_q;
      busy_d       = busy_q;
      case (state_q)
         ST_IDLE: begin
            if (accept_s) begin
               state_d = ST_EXEC;
               prio_d  = ~win_s;
               grant_d = win_s;
               in_1_d  = req_in_1[win_s];
               in_2_d  = req_in_2[win_s];
               ctrl_d  = req_control[win_s];
               busy_d  = 1'b1;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_EXEC: begin
            result_d              = alu_result;
            bcond_d               = alu_bcond;
            resp_valid_d          = '0;
            resp_valid_d[grant_q] = 1'b1;
            ctrl_d                = CTRL_IDLE;
            state_d               = ST_RESP;
         end
         ST_RESP: begin
            if (resp_fire_s) begin
               resp_valid_d = '0;
               busy_d       = 1'b0;
               state_d      = ST_IDLE;
            end else begin
               state_d = ST_RESP;
            end
         end
         default: begin
            state_d      = ST_IDLE;
            resp_valid_d = '0;
            busy_d       = 1'b0;
            ctrl_d       = CTRL_IDLE;
         end
      endcase
   end

   // State, operand and response registers; reset drops any in-flight operation.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= ST_IDLE;
         prio_q       <= 1'b0;
         grant_q      <= 1'b0;
         in_1_q       <= '0;
         in_2_q       <= '0;
         ctrl_q       <= CTRL_IDLE;
         result_q     <= '0;
         bcond_q      <= 1'b0;
         resp_valid_q <= '0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         prio_q       <= prio_d;
         grant_q      <= grant_d;
         in_1_q       <= in_1_d;
         in_2_q       <= in_2_d;
         ctrl_q       <= ctrl_d;
         result_q     <= result_d;
         bcond_q      <= bcond_d;
         resp_valid_q <= resp_valid_d;
         busy_q       <= busy_d;
      end
   end

   assign alu_in_1    = in_1_q;
   assign alu_in_2    = in_2_q;
   assign alu_control = ctrl_q;
   assign resp_valid  = resp_valid_q;
   assign resp_result = result_q;
   assign resp_bcond  = bcond_q;
   assign busy        = busy_q;
   assign grant_id    = grant_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter with a behavioural combinational ALU attached.
module tb_alu_share_arbiter;
   localparam int DW = 32;

   logic                  clk = 1'b0;
   logic                  reset_n = 1'b0;
   logic [1:0]            req_valid = 2'b00;
   logic [1:0]            req_ready;
   logic [1:0][DW-1:0]    req_in_1 = '0;
   logic [1:0][DW-1:0]    req_in_2 = '0;
   logic [1:0][3:0]       req_control = '0;
   logic [1:0]            resp_valid;
   logic [1:0]            resp_ready = 2'b00;
   logic [DW-1:0]         resp_result;
   logic                  resp_bcond;
   logic [DW-1:0]         alu_in_1, alu_in_2, alu_result;
   logic [3:0]            alu_control;
   logic                  alu_bcond;
   logic                  busy;
   logic                  grant_id;

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      logic          id;
      logic [DW-1:0] res;
      logic          bc;
   } exp_t;
   exp_t sb[$];

   alu_share_arbiter #(.NREQ(2), .DW(DW)) dut (
      .clk(clk), .reset_n(reset_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_in_1(req_in_1), .req_in_2(req_in_2), .req_control(req_control),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_result(resp_result), .resp_bcond(resp_bcond),
      .alu_in_1(alu_in_1), .alu_in_2(alu_in_2), .alu_control(alu_control),
      .alu_result(alu_result), .alu_bcond(alu_bcond),
      .busy(busy), .grant_id(grant_id)
   );

   always #5 clk = ~clk;

   // External ALU: compares report through bcond with result 0; undefined opcodes give 0/0.
   always_comb begin
      alu_result = '0;
      alu_bcond  = 1'b0;
      case (alu_control)
         4'd0:  alu_result = alu_in_1 + alu_in_2;
         4'd1:  alu_result = alu_in_1 - alu_in_2;
         4'd2:  alu_result = alu_in_1 & alu_in_2;
         4'd3:  alu_result = alu_in_1 | alu_in_2;
         4'd4:  alu_result = alu_in_1 ^ alu_in_2;
         4'd5:  alu_result = alu_in_1 << alu_in_2[4:0];
         4'd6:  alu_result = alu_in_1 >> alu_in_2[4:0];
         4'd7:  alu_bcond  = (alu_in_1 == alu_in_2);
         4'd8:  alu_bcond  = (alu_in_1 != alu_in_2);
         4'd9:  alu_bcond  = (alu_in_1 < alu_in_2);
         4'd10: alu_bcond  = (alu_in_1 >= alu_in_2);
         default: begin
            alu_result = '0;
            alu_bcond  = 1'b0;
         end
      endcase
   end

   task automatic do_reset();
      reset_n     = 1'b0;
      req_valid   = 2'b00;
      resp_ready  = 2'b00;
      req_in_1    = '0;
      req_in_2    = '0;
      req_control = '0;
      repeat (2) @(posedge clk);
      #2;
      reset_n = 1'b1;
      sb.delete();
   endtask

   task automatic test_reset();
      reset_n     = 1'b0;
      req_valid   = 2'b11;
      resp_ready  = 2'b00;
      req_in_1[0] = 32'h11;
      req_in_2[0] = 32'h22;
      repeat (2) @(posedge clk);
      #2;
      n_cmp++; if (req_ready !== 2'b00) begin n_err++; $display("FAIL rst_req_ready: got %b expected 00", req_ready); end
      n_cmp++; if (resp_valid !== 2'b00) begin n_err++; $display("FAIL rst_resp_valid: got %b expected 00", resp_valid); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b expected 0", busy); end
      n_cmp++; if (grant_id !== 1'b0) begin n_err++; $display("FAIL rst_grant_id: got %b expected 0", grant_id); end
      n_cmp++; if (alu_control !== 4'hF) begin n_err++; $display("FAIL rst_alu_control: got %0h expected f", alu_control); end
      n_cmp++; if (alu_in_1 !== '0 || alu_in_2 !== '0) begin n_err++; $display("FAIL rst_alu_in: got %0h/%0h expected 0/0", alu_in_1, alu_in_2); end
      n_cmp++; if (resp_result !== '0 || resp_bcond !== 1'b0) begin n_err++; $display("FAIL rst_resp: got %0h/%b expected 0/0", resp_result, resp_bcond); end
      reset_n = 1'b1;
      #1;
      n_cmp++; if (req_ready !== 2'b01) begin n_err++; $display("FAIL rst_priority: got %b expected 01", req_ready); end
      req_valid = 2'b00;
   endtask

   task automatic test_single_add();
      exp_t e;
      req_in_1[0]    = 32'd5;
      req_in_2[0]    = 32'd7;
      req_control[0] = 4'd0;
      req_valid[0]   = 1'b1;
      #1;
      n_cmp++; if (req_ready !== 2'b01) begin n_err++; $display("FAIL add_ready: got %b expected 01", req_ready); end
      sb.push_back('{id: 1'b0, res: 32'd12, bc: 1'b0});
      @(posedge clk); #2;
      req_valid[0] = 1'b0;
      n_cmp++; if (alu_control !== 4'd0) begin n_err++; $display("FAIL add_exec_ctrl: got %0h expected 0", alu_control); end
      n_cmp++; if (alu_in_1 !== 32'd5 || alu_in_2 !== 32'd7) begin n_err++; $display("FAIL add_exec_in: got %0d/%0d expected 5/7", alu_in_1, alu_in_2); end
      n_cmp++; if (busy !== 1'b1 || resp_valid !== 2'b00) begin n_err++; $display("FAIL add_exec_busy: got busy=%b rv=%b expected 1/00", busy, resp_valid); end
      @(posedge clk); #2;
      n_cmp++; if (resp_valid !== 2'b01) begin n_err++; $display("FAIL add_resp_valid: got %b expected 01", resp_valid); end
      if (sb.size() == 0) begin
         n_cmp++; n_err++; $display("FAIL add_sb_empty: got 0 entries expected 1");
      end else begin
         e = sb.pop_front();
         n_cmp++; if (resp_result !== e.res || resp_bcond !== e.bc) begin n_err++; $display("FAIL add_result: got %0d/%b expected %0d/%b", resp_result, resp_bcond, e.res, e.bc); end
      end
      n_cmp++; if (alu_control !== 4'hF) begin n_err++; $display("FAIL add_resp_ctrl: got %0h expected f", alu_control); end
      resp_ready[0] = 1'b1;
      @(posedge clk); #2;
      resp_ready[0] = 1'b0;
      n_cmp++; if (resp_valid !== 2'b00 || busy !== 1'b0) begin n_err++; $display("FAIL add_idle: got rv=%b busy=%b expected 00/0", resp_valid, busy); end
   endtask

   task automatic test_alternation();
      exp_t e;
      int ngrant, nresp, cyc;
      logic [1:0] exp_g;
      do_reset();
      req_in_1[0] = 32'd10;   req_in_2[0] = 32'd3;    req_control[0] = 4'd1;
      req_in_1[1] = 32'hF0;   req_in_2[1] = 32'hFF;   req_control[1] = 4'd4;
      req_valid  = 2'b11;
      resp_ready = 2'b11;
      ngrant = 0; nresp = 0; cyc = 0;
      while (nresp < 4 && cyc < 40) begin
         #1;
         if (req_ready != 2'b00) begin
            exp_g = ngrant[0] ? 2'b10 : 2'b01;
            n_cmp++; if (req_ready !== exp_g) begin n_err++; $display("FAIL alt_grant%0d: got %b expected %b", ngrant, req_ready, exp_g); end
            e.id  = req_ready[1];
            e.res = req_ready[1] ? 32'h0F : 32'd7;
            e.bc  = 1'b0;
            sb.push_back(e);
            ngrant++;
         end
         if (resp_valid != 2'b00) begin
            if (sb.size() == 0) begin
               n_cmp++; n_err++; $display("FAIL alt_sb_empty: got response %b expected none", resp_valid);
            end else begin
               e = sb.pop_front();
               exp_g = e.id ? 2'b10 : 2'b01;
               n_cmp++; if (resp_valid !== exp_g) begin n_err++; $display("FAIL alt_resp_idx%0d: got %b expected %b", nresp, resp_valid, exp_g); end
               n_cmp++; if (resp_result !== e.res || resp_bcond !== e.bc) begin n_err++; $display("FAIL alt_result%0d: got %0h/%b expected %0h/%b", nresp, resp_result, resp_bcond, e.res, e.bc); end
            end
            nresp++;
            if (nresp == 4) req_valid = 2'b00;
         end
         @(posedge clk); #2;
         cyc++;
      end
      n_cmp++; if (nresp != 4) begin n_err++; $display("FAIL alt_timeout: got %0d responses expected 4", nresp); end
      req_valid  = 2'b00;
      resp_ready = 2'b00;
   endtask

   task automatic test_ops();
      logic          ids [3] = '{1'b1, 1'b1, 1'b0};
      logic [3:0]    ctl [3] = '{4'd9, 4'd10, 4'd13};
      logic [DW-1:0] opa [3] = '{32'd3, 32'd3, 32'hDEADBEEF};
      logic [DW-1:0] opb [3] = '{32'd5, 32'd5, 32'h12345678};
      logic          ebc [3] = '{1'b1, 1'b0, 1'b0};
      exp_t e;
      logic id;
      logic [1:0] exp_v;
      int n, lat;
      for (int i = 0; i < 3; i++) begin
         id = ids[i];
         req_in_1[id]    = opa[i];
         req_in_2[id]    = opb[i];
         req_control[id] = ctl[i];
         req_valid[id]   = 1'b1;
         #1;
         n = 0;
         while (req_ready[id] !== 1'b1 && n < 10) begin @(posedge clk); #3; n++; end
         n_cmp++; if (req_ready[id] !== 1'b1) begin n_err++; $display("FAIL ops%0d_accept: got %b expected ready", i, req_ready); end
         sb.push_back('{id: id, res: 32'd0, bc: ebc[i]});
         @(posedge clk); #3;
         req_valid[id] = 1'b0;
         lat = 1;
         while (resp_valid == 2'b00 && lat < 10) begin @(posedge clk); #3; lat++; end
         n_cmp++; if (lat != 2) begin n_err++; $display("FAIL ops%0d_latency: got %0d expected 2", i, lat); end
         if (sb.size() == 0) begin
            n_cmp++; n_err++; $display("FAIL ops%0d_sb_empty: got 0 entries expected 1", i);
         end else begin
            e = sb.pop_front();
            exp_v = e.id ? 2'b10 : 2'b01;
            n_cmp++; if (resp_valid !== exp_v) begin n_err++; $display("FAIL ops%0d_resp_idx: got %b expected %b", i, resp_valid, exp_v); end
            n_cmp++; if (resp_result !== e.res || resp_bcond !== e.bc) begin n_err++; $display("FAIL ops%0d_result: got %0h/%b expected %0h/%b", i, resp_result, resp_bcond, e.res, e.bc); end
         end
         resp_ready[id] = 1'b1;
         @(posedge clk); #3;
         resp_ready[id] = 1'b0;
      end
   endtask

   task automatic test_backpressure();
      exp_t e;
      int n, lat;
      req_in_1[0] = 32'd1; req_in_2[0] = 32'd2; req_control[0] = 4'd0;
      req_valid[0] = 1'b1;
      #1;
      n = 0;
      while (req_ready[0] !== 1'b1 && n < 10) begin @(posedge clk); #3; n++; end
      n_cmp++; if (req_ready[0] !== 1'b1) begin n_err++; $display("FAIL bp_accept: got %b expected ready", req_ready); end
      sb.push_back('{id: 1'b0, res: 32'd3, bc: 1'b0});
      @(posedge clk); #3;
      req_valid[0] = 1'b0;
      req_in_1[1] = 32'd0; req_in_2[1] = 32'd0; req_control[1] = 4'd0;
      req_valid[1] = 1'b1;
      lat = 1;
      while (resp_valid == 2'b00 && lat < 10) begin @(posedge clk); #3; lat++; end
      if (sb.size() == 0) begin
         n_cmp++; n_err++; $display("FAIL bp_sb_empty: got 0 entries expected 1");
      end else begin
         e = sb.pop_front();
         for (int k = 0; k < 4; k++) begin
            n_cmp++; if (resp_result !== e.res || resp_valid !== 2'b01) begin n_err++; $display("FAIL bp_hold%0d: got %0d/%b expected %0d/01", k, resp_result, resp_valid, e.res); end
            n_cmp++; if (busy !== 1'b1 || req_ready !== 2'b00) begin n_err++; $display("FAIL bp_busy%0d: got busy=%b ready=%b expected 1/00", k, busy, req_ready); end
            @(posedge clk); #3;
         end
      end
      resp_ready[0] = 1'b1;
      @(posedge clk); #3;
      resp_ready[0] = 1'b0;
      n_cmp++; if (busy !== 1'b0 || resp_valid !== 2'b00) begin n_err++; $display("FAIL bp_release: got busy=%b rv=%b expected 0/00", busy, resp_valid); end
      n_cmp++; if (req_ready !== 2'b10) begin n_err++; $display("FAIL bp_idle_ready: got %b expected 10", req_ready); end
      req_valid[1] = 1'b0;
   endtask

   task automatic test_reset_mid_exec();
      int n;
      logic seen;
      req_in_1[0] = 32'd1; req_in_2[0] = 32'd1; req_control[0] = 4'd0;
      req_valid[0] = 1'b1;
      #1;
      n = 0;
      while (req_ready[0] !== 1'b1 && n < 10) begin @(posedge clk); #3; n++; end
      n_cmp++; if (req_ready[0] !== 1'b1) begin n_err++; $display("FAIL rx_accept: got %b expected ready", req_ready); end
      @(posedge clk); #3;
      req_valid[0] = 1'b0;
      n_cmp++; if (busy !== 1'b1 || alu_control !== 4'd0) begin n_err++; $display("FAIL rx_exec: got busy=%b ctrl=%0h expected 1/0", busy, alu_control); end
      #1;
      reset_n   = 1'b0;
      req_valid = 2'b11;
      #1;
      n_cmp++; if (busy !== 1'b0 || resp_valid !== 2'b00 || req_ready !== 2'b00) begin n_err++; $display("FAIL rx_async_ctrl: got busy=%b rv=%b rdy=%b expected 0/00/00", busy, resp_valid, req_ready); end
      n_cmp++; if (alu_control !== 4'hF || alu_in_1 !== '0 || alu_in_2 !== '0) begin n_err++; $display("FAIL rx_async_alu: got %0h %0h %0h expected f 0 0", alu_control, alu_in_1, alu_in_2); end
      n_cmp++; if (resp_result !== '0 || resp_bcond !== 1'b0 || grant_id !== 1'b0) begin n_err++; $display("FAIL rx_async_resp: got %0h/%b/%b expected 0/0/0", resp_result, resp_bcond, grant_id); end
      @(posedge clk); #4;
      reset_n = 1'b1;
      #1;
      n_cmp++; if (req_ready !== 2'b01) begin n_err++; $display("FAIL rx_first_grant: got %b expected 01", req_ready); end
      req_valid = 2'b00;
      seen = 1'b0;
      repeat (6) begin
         @(posedge clk); #3;
         if (resp_valid !== 2'b00) seen = 1'b1;
      end
      n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL rx_no_resp: got response after reset expected none"); end
      sb.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single_add();
      test_alternation();
      test_ops();
      test_backpressure();
      test_reset_mid_exec();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
